// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester at or above start, wrapping to 0.
module rr_arbiter_n #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = 32'(start) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_vld && |(req & (N_CH'(1) << idx))) begin
        grant     = SEL_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N:1 stream mux with fixed-select or round-robin arbitration and packet locking.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned W     = 3,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  state_t           state, state_next;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_next;
  logic [SEL_W-1:0] lock_ch, lock_ch_next;

  logic [SEL_W-1:0] sel_eff;
  logic [SEL_W-1:0] arb_grant;
  logic             arb_vld;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             space;
  logic             accept;
  logic [W-1:0]     g_data;
  logic             g_last;

  rr_arbiter_n #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_arb (
    .req      (in_valid),
    .start    (rr_ptr),
    .grant    (arb_grant),
    .grant_vld(arb_vld)
  );

  assign sel_eff = (32'(sel) >= N_CH) ? SEL_W'(N_CH - 1) : sel;
  assign space   = !out_valid || out_ready;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    unique case (state)
      ST_LOCKED: begin
        grant     = lock_ch;
        grant_vld = |(in_valid & (N_CH'(1) << lock_ch));
      end
      default: begin
        if (mode == MODE_RR) begin
          grant     = arb_grant;
          grant_vld = arb_vld;
        end else begin
          grant     = sel_eff;
          grant_vld = |(in_valid & (N_CH'(1) << sel_eff));
        end
      end
    endcase
  end

  assign accept   = space && grant_vld;
  // Gated by rst_n so no producer sees ready while reset is held.
  assign in_ready = (accept && rst_n) ? (N_CH'(1) << grant) : '0;

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) g_data = in_data[i*W +: W];
    end
    g_last = |(in_last & (N_CH'(1) << grant));
  end

  always_comb begin
    state_next   = state;
    lock_ch_next = lock_ch;
    rr_ptr_next  = rr_ptr;
    if (accept) begin
      if (g_last) begin
        state_next  = ST_IDLE;
        rr_ptr_next = (32'(grant) == N_CH - 1) ? '0 : grant + SEL_W'(1);
      end else if (state == ST_IDLE) begin
        state_next   = ST_LOCKED;
        lock_ch_next = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      lock_ch <= lock_ch_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n with N_CH=3, W=3 and channel data A=101, B=010, C=110.
module tb_stream_mux_n;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned W     = 3;
  localparam int unsigned SEL_W = 2;

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_last;
  logic [SEL_W-1:0]  out_ch;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;

  stream_mux_n #(
    .N_CH (N_CH),
    .W    (W),
    .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {3'b110, 3'b010, 3'b101};
    in_valid  = 3'b111;
    in_last   = 3'b111;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 3'b000) begin failures++; $display("FAIL reset_out_data got=%b exp=000", out_data); end
    checks++;
    if (out_ch !== 2'd0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_ch_last got=%0d/%b exp=0/0", out_ch, out_last); end
    checks++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    logic [W-1:0] exp_data [3];
    logic [2:0]   exp_rdy  [3];
    exp_data = '{3'b101, 3'b010, 3'b110};
    exp_rdy  = '{3'b001, 3'b010, 3'b100};
    mode = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = SEL_W'(s);
      #1;
      checks++;
      if (in_ready !== exp_rdy[s]) begin failures++; $display("FAIL fixed_in_ready sel=%0d got=%b exp=%b", s, in_ready, exp_rdy[s]); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[s] || out_ch !== SEL_W'(s)) begin
        failures++;
        $display("FAIL fixed_out sel=%0d got=v%b d%b ch%0d exp=v1 d%b ch%0d", s, out_valid, out_data, out_ch, exp_data[s], s);
      end
    end
  endtask

  task automatic test_clamp();
    sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 3'b100) begin failures++; $display("FAIL clamp_in_ready got=%b exp=100", in_ready); end
    tick();
    checks++;
    if (out_data !== 3'b110 || out_ch !== 2'd2) begin failures++; $display("FAIL clamp_out got=d%b ch%0d exp=d110 ch2", out_data, out_ch); end
    in_valid = 3'b001;
    #1;
    checks++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL clamp_no_fallback got=%b exp=000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL clamp_drain got=%b exp=0", out_valid); end
    in_valid = 3'b111;
  endtask

  task automatic test_rr();
    mode    = 1'b1;
    in_last = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SEL_W'(i % 3)) begin
        failures++;
        $display("FAIL rr_seq beat=%0d got=v%b ch%0d exp=v1 ch%0d", i, out_valid, out_ch, i % 3);
      end
    end
  endtask

  task automatic test_lock();
    mode    = 1'b0;
    sel     = 2'd1;
    in_last = 3'b000;
    tick();
    checks++;
    if (out_ch !== 2'd1 || out_data !== 3'b010 || out_last !== 1'b0) begin
      failures++; $display("FAIL lock_beat0 got=ch%0d d%b l%b exp=ch1 d010 l0", out_ch, out_data, out_last);
    end
    mode = 1'b1;
    sel  = 2'd0;
    #1;
    checks++;
    if (in_ready !== 3'b010) begin failures++; $display("FAIL lock_in_ready got=%b exp=010", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd1 || out_last !== 1'b0) begin failures++; $display("FAIL lock_beat1 got=ch%0d l%b exp=ch1 l0", out_ch, out_last); end
    in_last = 3'b010;
    tick();
    checks++;
    if (out_ch !== 2'd1 || out_last !== 1'b1) begin failures++; $display("FAIL lock_beat2 got=ch%0d l%b exp=ch1 l1", out_ch, out_last); end
    in_last = 3'b111;
    #1;
    checks++;
    if (in_ready !== 3'b100) begin failures++; $display("FAIL lock_next_rr got=%b exp=100", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd2 || out_data !== 3'b110) begin failures++; $display("FAIL lock_after got=ch%0d d%b exp=ch2 d110", out_ch, out_data); end
  endtask

  task automatic test_back_pressure();
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    out_ready = 1'b0;
    sel       = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 3'b000) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=000", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 3'b010 || out_ch !== 2'd1) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=v%b d%b ch%0d exp=v1 d010 ch1", i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b100) begin failures++; $display("FAIL bp_release_ready got=%b exp=100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 3'b110) begin failures++; $display("FAIL bp_no_gap got=v%b d%b exp=v1 d110", out_valid, out_data); end
  endtask

  task automatic test_reset_locked();
    mode    = 1'b0;
    sel     = 2'd0;
    in_last = 3'b000;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL rst_async_ready got=%b exp=000", in_ready); end
    tick();
    #2 rst_n = 1'b1;
    mode     = 1'b1;
    in_last  = 3'b111;
    in_valid = 3'b110;
    #1;
    checks++;
    if (in_ready !== 3'b010) begin failures++; $display("FAIL rst_idle got=%b exp=010", in_ready); end
    in_valid = 3'b111;
    #1;
    checks++;
    if (in_ready !== 3'b001) begin failures++; $display("FAIL rst_rr_ptr got=%b exp=001", in_ready); end
    tick();
    checks++;
    if (out_ch !== 2'd0 || out_data !== 3'b101) begin failures++; $display("FAIL rst_first_beat got=ch%0d d%b exp=ch0 d101", out_ch, out_data); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_clamp();
    test_rr();
    test_lock();
    test_back_pressure();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
